// File: rtl/nios_memory_arbiter_if.sv
// Avalon-MM style master port bundle for the RAM arbiter.
// master: drives address/data/strobes/lock; slave: returns waitrequest/readdata/readdatavalid.
interface nios_memory_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_memory_arbiter.sv
// Two-master round-robin arbiter with bounded lock in front of a 1-cycle RAM.
// Ports: clk, reset_n, m0/m1 (slave modports), ram_* towards the single-port RAM.
module nios_memory_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_memory_arbiter_if.slave m0,
  nios_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         rdv_q, rdv_d;

  logic               req0, req1;
  logic               gnt0, gnt1;
  logic               acc, win;
  logic               win_wr, win_lock;
  logic               own, own_lock;
  logic [CNT_W-1:0]   cnt_inc;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Grants are gated by reset_n so an asserted reset
  // forces waitrequest high immediately.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        LOCK0: gnt0 = req0;
        LOCK1: gnt1 = req1;
        default: begin
          gnt0 = req0 & (~req1 | last_q);
          gnt1 = req1 & (~req0 | ~last_q);
        end
      endcase
    end
  end

  assign acc      = gnt0 | gnt1;
  assign win      = gnt1;
  assign win_wr   = win ? m1.write : m0.write;
  assign win_lock = win ? m1.lock  : m0.lock;

  // Idle cycles leave the m0 inputs on the RAM bus.
  assign ram_address    = win ? m1.address    : m0.address;
  assign ram_byteenable = win ? m1.byteenable : m0.byteenable;
  assign ram_writedata  = win ? m1.writedata  : m0.writedata;
  assign ram_chipselect = acc;
  assign ram_write      = acc & win_wr;

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = rdv_q[0];
  assign m1.readdatavalid = rdv_q[1];

  // Write wins over read when both are raised.
  assign rdv_d[0] = gnt0 & m0.read & ~m0.write;
  assign rdv_d[1] = gnt1 & m1.read & ~m1.write;

  assign own      = (state_q == LOCK1);
  assign own_lock = own ? m1.lock : m0.lock;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOCK0, LOCK1: begin
        if (acc) last_d = own;
        if (!own_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (acc) begin
          if (cnt_inc == CNT_W'(LOCK_MAX)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        if (acc) begin
          last_d = win;
          if (win_lock && LOCK_MAX > 1) begin
            state_d = win ? LOCK1 : LOCK0;
            cnt_d   = CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rdv_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdv_q   <= rdv_d;
    end
  end

endmodule

// File: tb/tb_nios_memory_arbiter.sv
// Self-checking bench for nios_memory_arbiter with a RAM device model
// and a transaction-level reference model compared every cycle.
module tb_nios_memory_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nios_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  nios_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  logic [AW-1:0] ram_address;
  logic [3:0]    ram_byteenable;
  logic          ram_chipselect;
  logic          ram_write;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;

  nios_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .m0(m0_if),
    .m1(m1_if),
    .ram_address(ram_address),
    .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect),
    .ram_write(ram_write),
    .ram_writedata(ram_writedata),
    .ram_readdata(ram_readdata)
  );

  // RAM device: byte-enabled writes, registered read data
  logic [31:0] ram [1024];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[ram_address];
      end
    end
  end
  assign ram_readdata = ram_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: memory image, lock owner, tie preference, one pending read
  logic [31:0] mdl_mem [1024];
  int          lock_owner;
  int          lock_uses;
  int          prefer;
  bit          pend_v;
  int          pend_m;
  logic [31:0] pend_d;
  int          g;
  bit          r0, r1, ww, wl, ol;
  logic [9:0]  wa;
  logic [3:0]  wbe;
  logic [31:0] wwd;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_wait0", 32'(m0_if.waitrequest), 1);
      chk("rst_wait1", 32'(m1_if.waitrequest), 1);
      chk("rst_rdv0", 32'(m0_if.readdatavalid), 0);
      chk("rst_rdv1", 32'(m1_if.readdatavalid), 0);
      chk("rst_cs", 32'(ram_chipselect), 0);
      chk("rst_wr", 32'(ram_write), 0);
      lock_owner = -1;
      lock_uses  = 0;
      prefer     = 0;
      pend_v     = 1'b0;
    end else begin
      chk("m_rdv0", 32'(m0_if.readdatavalid), 32'(pend_v && pend_m == 0));
      chk("m_rdv1", 32'(m1_if.readdatavalid), 32'(pend_v && pend_m == 1));
      if (pend_v)
        chk("m_rdata", pend_m == 0 ? m0_if.readdata : m1_if.readdata, pend_d);
      pend_v = 1'b0;
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      g = -1;
      if (lock_owner == 0) g = r0 ? 0 : -1;
      else if (lock_owner == 1) g = r1 ? 1 : -1;
      else if (r0 && r1) g = prefer;
      else if (r0) g = 0;
      else if (r1) g = 1;
      chk("m_wait0", 32'(m0_if.waitrequest), 32'(g != 0));
      chk("m_wait1", 32'(m1_if.waitrequest), 32'(g != 1));
      chk("m_cs", 32'(ram_chipselect), 32'(g >= 0));
      if (g >= 0) begin
        if (g == 0) begin
          wa = m0_if.address; wbe = m0_if.byteenable;
          wwd = m0_if.writedata; ww = m0_if.write; wl = m0_if.lock;
        end else begin
          wa = m1_if.address; wbe = m1_if.byteenable;
          wwd = m1_if.writedata; ww = m1_if.write; wl = m1_if.lock;
        end
        chk("m_addr", 32'(ram_address), 32'(wa));
        chk("m_ram_wr", 32'(ram_write), 32'(ww));
        if (ww) begin
          chk("m_be", 32'(ram_byteenable), 32'(wbe));
          chk("m_wdata", ram_writedata, wwd);
          for (int b = 0; b < 4; b++)
            if (wbe[b]) mdl_mem[wa][8*b +: 8] = wwd[8*b +: 8];
        end else begin
          pend_v = 1'b1;
          pend_m = g;
          pend_d = mdl_mem[wa];
        end
        prefer = 1 - g;
      end else begin
        wl = 1'b0;
        chk("m_ram_wr_idle", 32'(ram_write), 0);
      end
      if (lock_owner < 0) begin
        if (g >= 0 && wl) begin
          lock_owner = g;
          lock_uses  = 1;
        end
      end else begin
        ol = (lock_owner == 0) ? m0_if.lock : m1_if.lock;
        if (!ol) lock_owner = -1;
        else if (g >= 0) begin
          lock_uses++;
          if (lock_uses == LM) lock_owner = -1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input int m, input bit rd, input bit wr, input bit lk,
                     input logic [9:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.lock = lk;
      m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = wd;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.lock = lk;
      m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = wd;
    end
  endtask

  task automatic idle_all();
    drv(0, 0, 0, 0, 10'h0, 4'hF, 32'h0);
    drv(1, 0, 0, 0, 10'h0, 4'hF, 32'h0);
  endtask

  int  n0;
  bit  found;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'h0;
      mdl_mem[i] = 32'h0;
    end
    reset_n = 1'b0;
    idle_all();
    look();
    chk("reset_wait0", 32'(m0_if.waitrequest), 1);
    chk("reset_cs", 32'(ram_chipselect), 0);
    step();
    step();
    reset_n = 1'b1;

    // both masters read continuously from reset: m0 first, then alternate
    drv(0, 1, 0, 0, 10'h020, 4'hF, 32'h0);
    drv(1, 1, 0, 0, 10'h021, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      look();
      chk("rr_wait0", 32'(m0_if.waitrequest), 32'(i % 2));
      chk("rr_wait1", 32'(m1_if.waitrequest), 32'((i + 1) % 2));
      chk("rr_rdv0", 32'(m0_if.readdatavalid), 32'(i % 2 == 1));
      chk("rr_rdv1", 32'(m1_if.readdatavalid), 32'(i >= 2 && i % 2 == 0));
      step();
    end
    idle_all();

    // single master write then read
    drv(0, 0, 1, 0, 10'h005, 4'hF, 32'hDEADBEEF);
    look();
    chk("s_wr_wait0", 32'(m0_if.waitrequest), 0);
    chk("s_ram_write", 32'(ram_write), 1);
    step();
    drv(0, 1, 0, 0, 10'h005, 4'hF, 32'h0);
    look();
    chk("s_rd_wait0", 32'(m0_if.waitrequest), 0);
    step();
    idle_all();
    look();
    chk("s_rdv0", 32'(m0_if.readdatavalid), 1);
    chk("s_rdata", m0_if.readdata, 32'hDEADBEEF);
    chk("s_rdv1", 32'(m1_if.readdatavalid), 0);
    step();

    // byte lanes
    drv(1, 0, 1, 0, 10'h030, 4'hF, 32'h0);
    step();
    drv(1, 0, 1, 0, 10'h030, 4'h2, 32'h11223344);
    step();
    drv(1, 1, 0, 0, 10'h030, 4'hF, 32'h0);
    step();
    idle_all();
    look();
    chk("be_rdv1", 32'(m1_if.readdatavalid), 1);
    chk("be_rdata", m1_if.readdata, 32'h00003300);
    step();

    // lock hold: m0 read+write under lock, m1 waits until lock drops
    drv(0, 1, 0, 1, 10'h010, 4'hF, 32'h0);
    drv(1, 1, 0, 0, 10'h011, 4'hF, 32'h0);
    look();
    chk("lk_wait0_a", 32'(m0_if.waitrequest), 0);
    chk("lk_wait1_a", 32'(m1_if.waitrequest), 1);
    step();
    drv(0, 0, 1, 1, 10'h010, 4'hF, 32'hCAFE0001);
    look();
    chk("lk_wait0_b", 32'(m0_if.waitrequest), 0);
    chk("lk_wait1_b", 32'(m1_if.waitrequest), 1);
    step();
    drv(0, 0, 0, 0, 10'h000, 4'hF, 32'h0);
    look();
    chk("lk_wait1_c", 32'(m1_if.waitrequest), 1);
    step();
    look();
    chk("lk_wait1_d", 32'(m1_if.waitrequest), 0);
    step();
    idle_all();

    // lock timeout after LM accepts
    drv(0, 1, 0, 1, 10'h040, 4'hF, 32'h0);
    drv(1, 1, 0, 0, 10'h041, 4'hF, 32'h0);
    n0 = 0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      look();
      if (!m1_if.waitrequest) found = 1'b1;
      else if (!m0_if.waitrequest) n0++;
      step();
    end
    chk("tmo_m1_granted", 32'(found), 1);
    chk("tmo_m0_accepts", 32'(n0), 32'(LM));
    drv(0, 1, 0, 0, 10'h040, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      look();
      chk("tmo_rr_wait0", 32'(m0_if.waitrequest), 32'(i % 2));
      chk("tmo_rr_wait1", 32'(m1_if.waitrequest), 32'((i + 1) % 2));
      step();
    end
    idle_all();
    step();

    // async reset right after an m1 read accept
    drv(1, 1, 0, 0, 10'h030, 4'hF, 32'h0);
    look();
    chk("ar_wait1", 32'(m1_if.waitrequest), 0);
    step();
    idle_all();
    chk("ar_rdv1_pre", 32'(m1_if.readdatavalid), 1);
    #1;
    drv(0, 1, 0, 0, 10'h030, 4'hF, 32'h0);
    drv(1, 1, 0, 0, 10'h031, 4'hF, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("ar_rdv1", 32'(m1_if.readdatavalid), 0);
    chk("ar_wait0", 32'(m0_if.waitrequest), 1);
    chk("ar_wait1", 32'(m1_if.waitrequest), 1);
    chk("ar_cs", 32'(ram_chipselect), 0);
    step();
    step();
    reset_n = 1'b1;
    look();
    chk("ar_post_wait0", 32'(m0_if.waitrequest), 0);
    chk("ar_post_wait1", 32'(m1_if.waitrequest), 1);
    step();
    idle_all();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
